// File: rtl/vu_level_detector.sv
// VU meter level detector: per-frame peak magnitude, bar ballistics, peak hold.
// Optional peak-hold FSM compiled in with `define VU_PEAK_HOLD_EN.
module vu_level_detector #(
  parameter int S_WIDTH      = 12,
  parameter int L_BITS       = 5,
  parameter int DECAY_FRAMES = 2,
  parameter int HOLD_FRAMES  = 30
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sample_valid,
  input  logic [S_WIDTH-1:0] sample,
  input  logic               frame_tick,
  output logic [L_BITS-1:0]  level,
  output logic [L_BITS-1:0]  peak,
  output logic               level_valid
);

  localparam int M_W = S_WIDTH - 1;
  localparam int D_W =
    (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;

  localparam logic [D_W-1:0] D_LAST =
    D_W'(DECAY_FRAMES - 1);
  localparam logic [D_W-1:0] D_ONE = D_W'(1);
  localparam logic [L_BITS-1:0] L_ONE = L_BITS'(1);
  localparam logic [L_BITS-1:0] L_ZERO = '0;

  logic [S_WIDTH-1:0] neg;
  logic               is_min;
  logic [M_W-1:0]     mag;

  logic [M_W-1:0]     acc;
  logic [M_W-1:0]     acc_nxt;

  logic [L_BITS-1:0]  q;
  logic [L_BITS-1:0]  lvl_dec;
  logic [L_BITS-1:0]  level_nxt;
  logic [D_W-1:0]     dcnt;
  logic [D_W-1:0]     dcnt_nxt;

  // Magnitude; the most negative sample saturates to full scale.
  always_comb begin
    neg    = ~sample + S_WIDTH'(1);
    is_min = sample[S_WIDTH-1] & ~|sample[S_WIDTH-2:0];
    mag    = sample[M_W-1:0];
    if (is_min)
      mag = '1;
    else if (sample[S_WIDTH-1])
      mag = neg[M_W-1:0];
  end

  // Window max; a sample on the tick opens the new window.
  always_comb begin
    acc_nxt = acc;
    if (frame_tick)
      acc_nxt = sample_valid ? mag : '0;
    else if (sample_valid && (mag > acc))
      acc_nxt = mag;
  end

  // Bar ballistics: instant attack, one step down per decay period.
  always_comb begin
    q         = acc[M_W-1 -: L_BITS];
    lvl_dec   = level - L_ONE;
    level_nxt = level;
    dcnt_nxt  = dcnt;
    if (frame_tick) begin
      unique case (1'b1)
        (q >= level): begin
          level_nxt = q;
          dcnt_nxt  = '0;
        end
        (q < level) && (dcnt == D_LAST): begin
          level_nxt = (lvl_dec > q) ? lvl_dec : q;
          dcnt_nxt  = '0;
        end
        default: begin
          dcnt_nxt = dcnt + D_ONE;
        end
      endcase
    end
  end

  // Accumulator, bar state and update strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc         <= '0;
      level       <= '0;
      dcnt        <= '0;
      level_valid <= 1'b0;
    end else begin
      acc         <= acc_nxt;
      level       <= level_nxt;
      dcnt        <= dcnt_nxt;
      level_valid <= frame_tick;
    end
  end

`ifdef VU_PEAK_HOLD_EN

  localparam int H_W =
    (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [H_W-1:0] H_LAST =
    H_W'(HOLD_FRAMES - 1);
  localparam logic [H_W-1:0] H_ONE = H_W'(1);

  typedef enum logic [1:0] {
    TRACK,
    HOLD,
    FALL
  } pk_state_t;

  pk_state_t         state;
  pk_state_t         state_nxt;
  logic [H_W-1:0]    hcnt;
  logic [H_W-1:0]    hcnt_nxt;
  logic [L_BITS-1:0] peak_q;
  logic [L_BITS-1:0] peak_nxt;
  logic [L_BITS-1:0] pk_dec;

  // Peak marker: hold after each new peak, then fall to the bar.
  always_comb begin
    state_nxt = state;
    hcnt_nxt  = hcnt;
    peak_nxt  = peak_q;
    pk_dec    = (peak_q == L_ZERO) ? L_ZERO
                                   : peak_q - L_ONE;
    if (frame_tick) begin
      unique case (state)
        TRACK: begin
          if (level_nxt >= peak_q) begin
            peak_nxt  = level_nxt;
            hcnt_nxt  = H_LAST;
            state_nxt = HOLD;
          end
        end
        HOLD: begin
          if (level_nxt > peak_q) begin
            peak_nxt = level_nxt;
            hcnt_nxt = H_LAST;
          end else if (hcnt == '0) begin
            state_nxt = FALL;
          end else begin
            hcnt_nxt = hcnt - H_ONE;
          end
        end
        FALL: begin
          if (level_nxt >= pk_dec) begin
            peak_nxt  = level_nxt;
            hcnt_nxt  = H_LAST;
            state_nxt = HOLD;
          end else begin
            peak_nxt = pk_dec;
          end
        end
        default: begin
          state_nxt = TRACK;
        end
      endcase
    end
  end

  // Peak FSM registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= TRACK;
      hcnt   <= '0;
      peak_q <= '0;
    end else begin
      state  <= state_nxt;
      hcnt   <= hcnt_nxt;
      peak_q <= peak_nxt;
    end
  end

  assign peak = peak_q;

`else

  assign peak = level;

`endif

endmodule

// File: tb/tb_vu_level_detector.sv
// Bench for vu_level_detector: directed scenarios plus random windows,
// every cycle checked against a frame-level reference model.
module tb_vu_level_detector;

  localparam int SW = 12;
  localparam int LB = 5;
  localparam int DF = 2;
  localparam int HF = 30;
  localparam int MAXMAG = (1 << (SW - 1)) - 1;
  localparam int SHIFT = SW - 1 - LB;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          sample_valid = 1'b0;
  logic [SW-1:0] sample = '0;
  logic          frame_tick = 1'b0;
  logic [LB-1:0] level;
  logic [LB-1:0] peak;
  logic          level_valid;

  int n_cmp = 0;
  int n_bad = 0;

  int m_acc = 0;
  int m_lvl = 0;
  int m_below = 0;
  int m_pk = 0;
  int m_since = 0;
  bit m_track = 1'b1;
  int m_vld = 0;

  always #5 clock = ~clock;

  vu_level_detector #(
    .S_WIDTH(SW),
    .L_BITS(LB),
    .DECAY_FRAMES(DF),
    .HOLD_FRAMES(HF)
  ) dut (
    .clock(clock),
    .reset(reset),
    .sample_valid(sample_valid),
    .sample(sample),
    .frame_tick(frame_tick),
    .level(level),
    .peak(peak),
    .level_valid(level_valid)
  );

  function automatic int mag_of(logic [SW-1:0] s);
    int v;
    v = $signed(s);
    if (v < 0) v = -v;
    if (v > MAXMAG) v = MAXMAG;
    return v;
  endfunction

  task automatic chk(string tag, int obs, int exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic model_edge(bit r, bit v, int mg, bit t);
    int nw;
    int dn;
    if (r) begin
      m_acc = 0; m_lvl = 0; m_below = 0;
      m_pk = 0; m_since = 0; m_track = 1'b1;
      m_vld = 0;
      return;
    end
    m_vld = t;
    if (!t) begin
      if (v && mg > m_acc) m_acc = mg;
      return;
    end
    nw = m_acc >> SHIFT;
    if (nw >= m_lvl) begin
      m_lvl = nw;
      m_below = 0;
    end else begin
      m_below++;
      if (m_below == DF) begin
        m_lvl = (m_lvl - 1 > nw) ? m_lvl - 1 : nw;
        m_below = 0;
      end
    end
`ifdef VU_PEAK_HOLD_EN
    dn = (m_pk > 0) ? m_pk - 1 : 0;
    if (m_track) begin
      if (m_lvl >= m_pk) begin
        m_pk = m_lvl; m_since = 0; m_track = 1'b0;
      end
    end else if (m_since < HF) begin
      if (m_lvl > m_pk) begin
        m_pk = m_lvl; m_since = 0;
      end else begin
        m_since++;
      end
    end else begin
      if (m_lvl >= dn) begin
        m_pk = m_lvl; m_since = 0;
      end else begin
        m_pk = dn;
      end
    end
`else
    dn = 0;
    m_pk = m_lvl + dn;
`endif
    m_acc = v ? mg : 0;
  endtask

  task automatic cyc(bit r, bit v,
                     logic [SW-1:0] s, bit t);
    @(negedge clock);
    reset = r;
    sample_valid = v;
    sample = s;
    frame_tick = t;
    @(posedge clock);
    model_edge(r, v, mag_of(s), t);
    #1;
    chk("level", level, m_lvl);
    chk("peak", peak, m_pk);
    chk("valid", level_valid, m_vld);
  endtask

  task automatic tick();
    cyc(1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    int exp;
    int mask;

    // Reset with samples and ticks active.
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b1, SW'($urandom), i[0]);
    for (int i = 0; i < 4; i++) idle();
    chk("rst_level", level, 0);
    chk("rst_peak", peak, 0);
    chk("rst_valid", level_valid, 0);

    // Attack and quantization.
    cyc(1'b0, 1'b1, 12'h100, 1'b0);
    cyc(1'b0, 1'b1, 12'h400, 1'b0);
    cyc(1'b0, 1'b1, 12'h200, 1'b0);
    tick();
    chk("atk_level", level, 16);
    chk("atk_peak", peak, 16);
    chk("atk_valid", level_valid, 1);
    idle();
    chk("atk_valid_low", level_valid, 0);
    chk("atk_hold", level, 16);

    // Silent frames: bar decays 1 step per 2 ticks.
    for (int i = 1; i <= 60; i++) begin
      tick();
      exp = 16 - i / 2;
      if (exp < 0) exp = 0;
      chk("dec_level", level, exp);
      idle();
      idle();
    end

    // Most negative sample saturates to full scale.
    cyc(1'b0, 1'b1, 12'h800, 1'b0);
    idle();
    tick();
    chk("sat_level", level, 31);
    chk("sat_peak", peak, 31);

    for (int i = 0; i < 70; i++) begin
      tick();
      idle();
    end
    chk("drain_level", level, 0);

    // Sample coinciding with the tick opens the new window.
    cyc(1'b0, 1'b1, 12'h7FF, 1'b1);
    chk("bnd_first", level, 0);
    idle();
    tick();
    chk("bnd_second", level, 31);

    // Back-to-back ticks.
    cyc(1'b0, 1'b1, 12'h300, 1'b1);
    tick();
    tick();
    tick();

    // Reset mid-frame drops the window.
    cyc(1'b0, 1'b1, 12'h600, 1'b0);
    cyc(1'b1, 1'b1, 12'h600, 1'b0);
    idle();
    tick();
    chk("rst_mid_level", level, 0);

    // Random windows with varying amplitude.
    mask = 12'hFFF;
    for (int i = 0; i < 4000; i++) begin
      bit r, v, t;
      r = ($urandom_range(0, 799) == 0);
      v = ($urandom_range(0, 2) != 0);
      t = ($urandom_range(0, 11) == 0);
      if (t) mask = (1 << $urandom_range(4, 12)) - 1;
      cyc(r, v, SW'($urandom & mask), t);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
